pipe_stall_ctrl: RTL and testbench

- Hazard and stall sequencer for the 5-stage pipeline.
- Drives the enable/clear controls of the 32-bit enable-flop pipeline registers: PC, IF/ID and the ID/EX bubble mux.
- Handles load-use hazards, multi-cycle mul/div occupancy, instruction-memory wait and taken-branch flush.
- Keeps a free-running stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Hazard and stall sequencer for the 5-stage pipeline. It drives the enable
// and clear controls of the PC, IF/ID and ID/EX pipeline registers. It also
// handles the following cases:
//   - load-use hazards
//   - multi-cycle mul/div occupancy of EX
//   - instruction-memory wait
//   - taken-branch flush
// A free-running counter records how many cycles the PC was held.
//
// Parameters:
//   MD_LATENCY   cycles the mul/div unit occupies EX after issue (2..64)
//   CNT_W        width of the mul/div countdown; must hold MD_LATENCY-1
//
// Ports:
//   Clk            clock; all state updates on posedge
//   Clrn           asynchronous active-low reset
//   id_rs, id_rt   source register fields of the instruction in ID
//   id_use_rs/rt   ID instruction actually reads rs / rt
//   id_is_md       ID instruction is a mul/div
//   ex_wreg        EX instruction writes the register file
//   ex_m2reg       EX instruction is a load
//   ex_rd          EX destination register
//   branch_taken   branch in ID resolved taken this cycle
//   imem_ready     instruction memory returns valid data this cycle
//   pc_en          PC register enable
//   ifid_en        IF/ID register enable
//   ifid_flush     IF/ID loads a NOP instead of the fetched word
//   idex_bubble    ID/EX loads all-zero control
//   md_start       one-cycle issue pulse to the mul/div unit
//   md_busy        mul/div in progress
//   stall_cycles   number of cycles with pc_en low (wraps)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 6
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_md,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MD_CNT_INIT = CNT_W'(MD_LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_q;

  logic load_use;
  logic freeze;

  // A load in EX whose destination is read by ID cannot be forwarded in time.
  // Register 0 is hardwired, so writes to it never create a hazard.
  assign load_use = ex_m2reg & ex_wreg & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) |
                     (id_use_rt & (id_rt == ex_rd)));

  assign freeze = load_use | ~imem_ready;

  // State register. The countdown is loaded with MD_LATENCY-1 on issue and
  // the cnt==0 cycle is still busy. This gives exactly MD_LATENCY busy cycles.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter samples the combinational pc_en. While Clrn is low the flop
  // is held in reset, so reset cycles are never counted.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    md_start    = 1'b0;
    md_busy     = 1'b0;

    case (state_q)
      RUN: begin
        // A frozen cycle issues nothing. A mul/div or branch seen while
        // frozen is picked up again once the hazard or wait clears.
        if (!freeze) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_bubble = 1'b0;
          ifid_flush  = branch_taken;
          if (id_is_md) begin
            md_start = 1'b1;
            state_d  = MD_BUSY;
            cnt_d    = MD_CNT_INIT;
          end
        end
      end

      MD_BUSY: begin
        // The whole front end is held. Branch, hazard and fetch inputs are
        // ignored until EX is free again.
        md_busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Outputs show their reset values as soon as Clrn goes low, without
    // waiting for the flops to be cleared at a clock edge.
    if (!Clrn) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      md_start    = 1'b0;
      md_busy     = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic        Clk;
  logic        Clrn;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_is_md;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic        imem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        md_start;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int          n_cmp;
  int          n_mis;
  logic [31:0] exp_stall;

  pipe_stall_ctrl #(
    .MD_LATENCY(8),
    .CNT_W(6)
  ) dut (
    .Clk(Clk),
    .Clrn(Clrn),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_is_md(id_is_md),
    .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg),
    .ex_rd(ex_rd),
    .branch_taken(branch_taken),
    .imem_ready(imem_ready),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .md_start(md_start),
    .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all six control outputs. The expected order is
  // pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy.
  task automatic chk_ctl(input string tag, input logic e_pc, input logic e_ifid,
                         input logic e_flush, input logic e_bub,
                         input logic e_start, input logic e_busy);
    chk({tag, ".pc_en"},       {31'd0, pc_en},       {31'd0, e_pc});
    chk({tag, ".ifid_en"},     {31'd0, ifid_en},     {31'd0, e_ifid});
    chk({tag, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, e_flush});
    chk({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, e_bub});
    chk({tag, ".md_start"},    {31'd0, md_start},    {31'd0, e_start});
    chk({tag, ".md_busy"},     {31'd0, md_busy},     {31'd0, e_busy});
    $display("[%0t] %s: pc_en=%0b ifid_en=%0b flush=%0b bubble=%0b start=%0b busy=%0b stall=%0d",
             $time, tag, pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy, stall_cycles);
  endtask

  // Advances one clock. It then checks the counter against the bench's
  // own running total.
  task automatic tick(input bit stalled);
    @(posedge Clk);
    #1;
    if (stalled) exp_stall = exp_stall + 32'd1;
    chk("stall_cycles", stall_cycles, exp_stall);
  endtask

  task automatic idle();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_use_rs    = 1'b0;
    id_use_rt    = 1'b0;
    id_is_md     = 1'b0;
    ex_wreg      = 1'b0;
    ex_m2reg     = 1'b0;
    ex_rd        = 5'd0;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
  endtask

  // Runs eight busy cycles. Distracting inputs are toggled to show they are
  // ignored while busy.
  task automatic busy_window(input string tag);
    for (int i = 0; i < 8; i++) begin
      idle();
      branch_taken = (i == 3);
      imem_ready   = (i != 5);
      id_is_md     = (i == 6);
      #1;
      chk_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b1);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    exp_stall = 32'd0;
    idle();
    Clrn = 1'b0;

    // Reset values are visible with no clock edge yet.
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset.stall", stall_cycles, 32'd0);
    @(posedge Clk);
    #1;
    chk("reset_hold.stall", stall_cycles, 32'd0);
    Clrn = 1'b1;
    #1;
    chk_ctl("release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // Load-use hazard on rs.
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    chk_ctl("loaduse_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1);

    // Writes to r0 never create a hazard.
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    chk_ctl("loaduse_r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // Load-use hazard on rt.
    idle();
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
    #1;
    chk_ctl("loaduse_rt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1);

    // A matching register that is not read does not stall.
    id_use_rt = 1'b0;
    #1;
    chk_ctl("nouse_rt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // Taken branch flushes IF/ID.
    idle();
    branch_taken = 1'b1;
    #1;
    chk_ctl("branch", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // Mul/div issue, then exactly eight busy cycles.
    idle();
    id_is_md = 1'b1;
    #1;
    chk_ctl("md_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);
    busy_window("md_busy");

    // Back-to-back: the very next RUN cycle issues again.
    idle();
    id_is_md = 1'b1;
    #1;
    chk_ctl("md_b2b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);
    busy_window("md_busy2");
    idle();
    #1;
    chk_ctl("md_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // Priority: a freeze beats mul/div and branch.
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    branch_taken = 1'b1; id_is_md = 1'b1;
    #1;
    chk_ctl("prio_freeze", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1);
    ex_m2reg = 1'b0;
    #1;
    chk_ctl("prio_go", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0);
    busy_window("prio_busy");

    // Instruction-memory wait for three cycles.
    for (int i = 0; i < 3; i++) begin
      idle();
      imem_ready   = 1'b0;
      branch_taken = (i == 1);
      #1;
      chk_ctl("imem_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1);
    end
    idle();
    #1;
    chk_ctl("imem_ready", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // Reset in the middle of MD_BUSY, when cnt is 4.
    id_is_md = 1'b1;
    #1;
    chk_ctl("rst_md_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl("rst_md_busy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b1);
    end
    Clrn = 1'b0;
    #1;
    chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_stall = 32'd0;
    chk("rst_mid.stall", stall_cycles, exp_stall);
    @(posedge Clk);
    #1;
    chk_ctl("rst_mid_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    Clrn = 1'b1;
    #1;
    chk_ctl("rst_release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    #1;
    chk_ctl("rst_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // The counter wraps from all-ones to zero.
    force dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_q;
    #1;
    exp_stall = 32'hFFFF_FFFF;
    chk("wrap_preset", stall_cycles, exp_stall);
    imem_ready = 1'b0;
    #1;
    chk_ctl("wrap_stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1);
    chk("wrap_zero", stall_cycles, 32'd0);
    idle();
    tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
